// File: rtl/parking_lot_ctrl_param.sv
// Parametrised parking-lot core: slot allocation, single elevator moving one floor
// per cycle, plate/timestamp storage and a saturating time-based exit fee.
`timescale 1ns/1ps
module parking_lot_ctrl_param #(
    parameter int FLOORS  = 7,
    parameter int SLOTS   = 8,
    parameter int PLATE_W = 16,
    parameter int FEE_W   = 8,
    parameter int TIME_W  = 16,
    parameter int RATE    = 1,
    localparam int FW = $clog2(FLOORS + 1),
    localparam int CW = $clog2(FLOORS * SLOTS / 2 + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          in_mode,
    input  logic                          out_mode,
    input  logic [PLATE_W-1:0]            license_plate,
    input  logic [FLOORS-1:0]             leakage_mask,
    output logic [FLOORS*SLOTS*PLATE_W-1:0] parked,
    output logic [FW-1:0]                 current_floor,
    output logic [PLATE_W-1:0]            moving,
    output logic                          plate_type,
    output logic [FEE_W-1:0]              fee,
    output logic [CW-1:0]                 empty_suv,
    output logic [CW-1:0]                 empty_sedan,
    output logic                          full_suv,
    output logic                          full_sedan,
    output logic                          done,
    output logic                          err
);
    localparam int NS = FLOORS * SLOTS;
    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [FEE_W-1:0] FEE_MAX = '1;

    typedef enum logic [2:0] {IDLE, SEARCH, UP, SERVICE, DOWN, RELEASE} state_t;

    state_t              state;
    logic [PLATE_W-1:0]  req_plate;
    logic                req_park;
    logic                req_bad;
    logic [FW-1:0]       tgt_floor;
    logic [SW-1:0]       tgt_slot;
    logic [TIME_W-1:0]   cnt;
    logic [TIME_W-1:0]   stamp [NS];

    logic                hit_found;
    logic [FW-1:0]       hit_floor;
    logic [SW-1:0]       hit_slot;
    logic                free_found;
    logic [FW-1:0]       free_floor;
    logic [SW-1:0]       free_slot;
    logic                reject;
    logic [IW-1:0]       tgt_idx;
    logic [TIME_W-1:0]   elapsed;
    logic [TIME_W+31:0]  fee_wide;
    logic [FEE_W-1:0]    fee_next;

    assign req_ready = (state == IDLE);

    // Lowest-first scan: plate lookup ignores the mask, allocation honours it.
    always_comb begin
        hit_found  = 1'b0;
        hit_floor  = '0;
        hit_slot   = '0;
        free_found = 1'b0;
        free_floor = '0;
        free_slot  = '0;
        for (int f = 0; f < FLOORS; f++) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (!hit_found && parked[(f*SLOTS+s)*PLATE_W +: PLATE_W] == req_plate) begin
                    hit_found = 1'b1;
                    hit_floor = FW'(f + 1);
                    hit_slot  = SW'(s);
                end
                if (!free_found && !leakage_mask[f] &&
                    parked[(f*SLOTS+s)*PLATE_W +: PLATE_W] == '0 &&
                    ((s < SLOTS/2) == plate_type)) begin
                    free_found = 1'b1;
                    free_floor = FW'(f + 1);
                    free_slot  = SW'(s);
                end
            end
        end
    end

    always_comb begin
        empty_suv   = '0;
        empty_sedan = '0;
        for (int f = 0; f < FLOORS; f++) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (!leakage_mask[f] && parked[(f*SLOTS+s)*PLATE_W +: PLATE_W] == '0) begin
                    if (s < SLOTS/2) empty_suv   = empty_suv + CW'(1);
                    else             empty_sedan = empty_sedan + CW'(1);
                end
            end
        end
    end

    assign full_suv   = (empty_suv == '0);
    assign full_sedan = (empty_sedan == '0);

    assign reject = req_bad || (req_plate == '0) ||
                    (req_park && (hit_found || !free_found)) ||
                    (!req_park && !hit_found);

    assign tgt_idx  = IW'((int'(tgt_floor) - 1) * SLOTS + int'(tgt_slot));
    assign elapsed  = cnt - stamp[tgt_idx];
    assign fee_wide = {32'd0, elapsed} * (TIME_W+32)'(RATE);
    assign fee_next = (fee_wide > (TIME_W+32)'(FEE_MAX)) ? FEE_MAX : fee_wide[FEE_W-1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            req_plate     <= '0;
            req_park      <= 1'b0;
            req_bad       <= 1'b0;
            tgt_floor     <= '0;
            tgt_slot      <= '0;
            cnt           <= '0;
            parked        <= '0;
            current_floor <= '0;
            moving        <= '0;
            plate_type    <= 1'b0;
            fee           <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            for (int i = 0; i < NS; i++) stamp[i] <= '0;
        end else begin
            cnt  <= cnt + TIME_W'(1);
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_plate  <= license_plate;
                        req_park   <= in_mode;
                        req_bad    <= (in_mode == out_mode);
                        plate_type <= license_plate[0];
                        state      <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (reject) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tgt_floor <= req_park ? free_floor : hit_floor;
                        tgt_slot  <= req_park ? free_slot  : hit_slot;
                        moving    <= req_park ? req_plate  : '0;
                        state     <= UP;
                    end
                end
                UP: begin
                    current_floor <= current_floor + FW'(1);
                    if (current_floor + FW'(1) == tgt_floor) state <= SERVICE;
                end
                SERVICE: begin
                    if (req_park) begin
                        parked[int'(tgt_idx)*PLATE_W +: PLATE_W] <= req_plate;
                        stamp[tgt_idx] <= cnt;
                        moving         <= '0;
                    end else begin
                        parked[int'(tgt_idx)*PLATE_W +: PLATE_W] <= '0;
                        moving <= req_plate;
                        fee    <= fee_next;
                    end
                    state <= DOWN;
                end
                DOWN: begin
                    current_floor <= current_floor - FW'(1);
                    if (current_floor == FW'(1)) state <= RELEASE;
                end
                RELEASE: begin
                    moving <= '0;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_parking_lot_ctrl_param.sv
// Directed bench for parking_lot_ctrl_param with default parameters (7 floors x 8 slots).
`timescale 1ns/1ps
module tb_parking_lot_ctrl_param;
    logic         clock = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic         in_mode;
    logic         out_mode;
    logic [15:0]  license_plate;
    logic [6:0]   leakage_mask;
    logic [895:0] parked;
    logic [2:0]   current_floor;
    logic [15:0]  moving;
    logic         plate_type;
    logic [7:0]   fee;
    logic [4:0]   empty_suv;
    logic [4:0]   empty_sedan;
    logic         full_suv;
    logic         full_sedan;
    logic         done;
    logic         err;

    int checks = 0;
    int errors = 0;
    logic [895:0] exp_parked;

    parking_lot_ctrl_param dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .in_mode(in_mode), .out_mode(out_mode), .license_plate(license_plate),
        .leakage_mask(leakage_mask), .parked(parked), .current_floor(current_floor),
        .moving(moving), .plate_type(plate_type), .fee(fee), .empty_suv(empty_suv),
        .empty_sedan(empty_sedan), .full_suv(full_suv), .full_sedan(full_sedan),
        .done(done), .err(err)
    );

    always #5 clock = ~clock;

    // Posedges fall at 5, 15, 25 ... so edge k sits at time 10k+5.
    function automatic int edge_now();
        return int'(($time - 5) / 10);
    endfunction

    function automatic int slot_base(input int floor, input int slot);
        return ((floor - 1) * 8 + slot) * 16;
    endfunction

    task automatic do_reset();
        reset         = 1'b0;
        req_valid     = 1'b0;
        in_mode       = 1'b0;
        out_mode      = 1'b0;
        license_plate = '0;
        leakage_mask  = '0;
        exp_parked    = '0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic send_req(input logic im, input logic om, input logic [15:0] plate, output int acc);
        in_mode       = im;
        out_mode      = om;
        license_plate = plate;
        req_valid     = 1'b1;
        acc           = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (req_ready) begin
                @(posedge clock);
                acc = edge_now();
                break;
            end
        end
        #1 req_valid = 1'b0;
        if (acc < 0) begin
            checks++; errors++;
            $display("[TB] FAIL accept_timeout: plate %h never accepted, required acceptance", plate);
        end
    endtask

    task automatic wait_pulse(input bit want_done, input int bound, output int at_edge,
                              output int max_floor, output bit jumped);
        int prev;
        prev      = int'(current_floor);
        at_edge   = -1;
        max_floor = prev;
        jumped    = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clock);
            #1;
            if (int'(current_floor) > max_floor) max_floor = int'(current_floor);
            if (int'(current_floor) - prev > 1 || prev - int'(current_floor) > 1) jumped = 1'b1;
            prev = int'(current_floor);
            if ((want_done && done) || (!want_done && err)) begin
                at_edge = edge_now();
                break;
            end
        end
        if (at_edge < 0) begin
            checks++; errors++;
            $display("[TB] FAIL pulse_timeout: no %s pulse within %0d cycles", want_done ? "done" : "err", bound);
        end
    endtask

    task automatic test_reset();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready: got %b want 1", req_ready); end
        checks++; if (current_floor !== 3'd0) begin errors++; $display("[TB] FAIL rst_floor: got %0d want 0", current_floor); end
        checks++; if (moving !== 16'h0) begin errors++; $display("[TB] FAIL rst_moving: got %h want 0", moving); end
        checks++; if (fee !== 8'd0) begin errors++; $display("[TB] FAIL rst_fee: got %0d want 0", fee); end
        checks++; if (parked !== '0) begin errors++; $display("[TB] FAIL rst_parked: lot not empty"); end
        checks++; if (empty_suv !== 5'd28 || empty_sedan !== 5'd28) begin errors++; $display("[TB] FAIL rst_empty: got %0d/%0d want 28/28", empty_suv, empty_sedan); end
        checks++; if (full_suv !== 1'b0 || full_sedan !== 1'b0) begin errors++; $display("[TB] FAIL rst_full: got %b%b want 00", full_suv, full_sedan); end
        checks++; if (done !== 1'b0 || err !== 1'b0 || plate_type !== 1'b0) begin errors++; $display("[TB] FAIL rst_pulses: done %b err %b type %b want 000", done, err, plate_type); end
    endtask

    task automatic test_park_suv();
        int acc, d, mf;
        bit j;
        send_req(1'b1, 1'b0, 16'h9423, acc);
        @(posedge clock); #1;
        checks++; if (moving !== 16'h9423) begin errors++; $display("[TB] FAIL park_moving: got %h want 9423", moving); end
        checks++; if (plate_type !== 1'b1) begin errors++; $display("[TB] FAIL park_type: got %b want 1", plate_type); end
        wait_pulse(1'b1, 30, d, mf, j);
        exp_parked[slot_base(1, 0) +: 16] = 16'h9423;
        checks++; if (d - acc !== 5) begin errors++; $display("[TB] FAIL park_latency: got %0d want 5", d - acc); end
        checks++; if (mf !== 1 || j !== 1'b0) begin errors++; $display("[TB] FAIL park_path: max floor %0d jump %b want 1/0", mf, j); end
        checks++; if (parked !== exp_parked) begin errors++; $display("[TB] FAIL park_slot: f1s0 got %h want 9423", parked[15:0]); end
        checks++; if (empty_suv !== 5'd27) begin errors++; $display("[TB] FAIL park_empty: got %0d want 27", empty_suv); end
        checks++; if (current_floor !== 3'd0 || moving !== 16'h0) begin errors++; $display("[TB] FAIL park_home: floor %0d moving %h want 0/0", current_floor, moving); end
    endtask

    task automatic test_fee();
        int accp, accr, d, mf;
        bit j;
        send_req(1'b1, 1'b0, 16'h8754, accp);
        wait_pulse(1'b1, 30, d, mf, j);
        exp_parked[slot_base(1, 4) +: 16] = 16'h8754;
        checks++; if (parked !== exp_parked) begin errors++; $display("[TB] FAIL sedan_slot: f1s4 got %h want 8754", parked[slot_base(1, 4) +: 16]); end
        // Retrieve accepted 20 edges after park acceptance puts the two SERVICE edges 20 apart.
        while (edge_now() < accp + 19) begin @(posedge clock); #1; end
        send_req(1'b0, 1'b1, 16'h8754, accr);
        checks++; if (accr !== accp + 20) begin errors++; $display("[TB] FAIL ret_accept: edge %0d want %0d", accr, accp + 20); end
        @(posedge clock); #1;
        checks++; if (moving !== 16'h0) begin errors++; $display("[TB] FAIL ret_up_empty: got %h want 0", moving); end
        repeat (2) begin @(posedge clock); #1; end
        exp_parked[slot_base(1, 4) +: 16] = 16'h0;
        checks++; if (moving !== 16'h8754) begin errors++; $display("[TB] FAIL ret_moving: got %h want 8754", moving); end
        checks++; if (fee !== 8'd20) begin errors++; $display("[TB] FAIL ret_fee: got %0d want 20", fee); end
        checks++; if (parked !== exp_parked) begin errors++; $display("[TB] FAIL ret_clear: f1s4 got %h want 0", parked[slot_base(1, 4) +: 16]); end
        wait_pulse(1'b1, 30, d, mf, j);
        checks++; if (d - accr !== 5 || moving !== 16'h0) begin errors++; $display("[TB] FAIL ret_done: latency %0d moving %h want 5/0", d - accr, moving); end
    endtask

    task automatic test_leakage();
        int acc, d, mf;
        bit j;
        do_reset();
        leakage_mask = 7'b0000001;
        #1;
        checks++; if (empty_suv !== 5'd24 || empty_sedan !== 5'd24) begin errors++; $display("[TB] FAIL leak_empty: got %0d/%0d want 24/24", empty_suv, empty_sedan); end
        send_req(1'b1, 1'b0, 16'h9423, acc);
        @(posedge clock); #1;
        leakage_mask = 7'b0000000;
        wait_pulse(1'b1, 40, d, mf, j);
        exp_parked[slot_base(2, 0) +: 16] = 16'h9423;
        checks++; if (d - acc !== 7) begin errors++; $display("[TB] FAIL leak_latency: got %0d want 7", d - acc); end
        checks++; if (mf !== 2 || j !== 1'b0) begin errors++; $display("[TB] FAIL leak_path: max floor %0d jump %b want 2/0", mf, j); end
        checks++; if (parked !== exp_parked) begin errors++; $display("[TB] FAIL leak_slot: f2s0 got %h want 9423", parked[slot_base(2, 0) +: 16]); end
    endtask

    task automatic test_errors();
        logic        ims [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic        oms [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [15:0] pls [4] = '{16'h5555, 16'h9423, 16'h7777, 16'h0000};
        int acc, e, mf;
        bit j;
        for (int k = 0; k < 4; k++) begin
            send_req(ims[k], oms[k], pls[k], acc);
            wait_pulse(1'b0, 10, e, mf, j);
            checks++; if (e - acc !== 1 || req_ready !== 1'b1) begin errors++; $display("[TB] FAIL err_case%0d_timing: latency %0d ready %b want 1/1", k, e - acc, req_ready); end
            checks++; if (mf !== 0 || moving !== 16'h0 || parked !== exp_parked) begin errors++; $display("[TB] FAIL err_case%0d_state: floor %0d moving %h want no change", k, mf, moving); end
            @(posedge clock); #1;
            checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL err_case%0d_pulse: err %b want 0 after one cycle", k, err); end
        end
    endtask

    task automatic test_full();
        int acc, d, mf, bad;
        bit j;
        logic [15:0] p;
        do_reset();
        bad = 0;
        for (int i = 0; i < 28; i++) begin
            p = 16'h1001 + 16'(i << 4);
            send_req(1'b1, 1'b0, p, acc);
            wait_pulse(1'b1, 40, d, mf, j);
            exp_parked[slot_base(i / 4 + 1, i % 4) +: 16] = p;
            checks++; if (d - acc !== 2 * (i / 4 + 1) + 3) begin errors++; $display("[TB] FAIL fill_latency%0d: got %0d want %0d", i, d - acc, 2 * (i / 4 + 1) + 3); end
        end
        checks++; if (parked !== exp_parked) begin errors++; $display("[TB] FAIL fill_layout: SUV slots not filled floor/slot ascending"); end
        checks++; if (full_suv !== 1'b1 || empty_suv !== 5'd0) begin errors++; $display("[TB] FAIL fill_full: full %b empty %0d want 1/0", full_suv, empty_suv); end
        checks++; if (full_sedan !== 1'b0 || empty_sedan !== 5'd28) begin errors++; $display("[TB] FAIL fill_sedan: full %b empty %0d want 0/28", full_sedan, empty_sedan); end
        send_req(1'b1, 1'b0, 16'h1111, acc);
        wait_pulse(1'b0, 10, d, mf, j);
        checks++; if (d - acc !== 1 || mf !== 0) begin errors++; $display("[TB] FAIL full_reject: latency %0d max floor %0d want 1/0", d - acc, mf); end
        send_req(1'b1, 1'b0, 16'h2222, acc);
        wait_pulse(1'b1, 30, d, mf, j);
        exp_parked[slot_base(1, 4) +: 16] = 16'h2222;
        checks++; if (d - acc !== 5 || parked !== exp_parked) begin errors++; $display("[TB] FAIL full_sedan_park: latency %0d f1s4 %h want 5/2222", d - acc, parked[slot_base(1, 4) +: 16]); end
    endtask

    task automatic test_saturate();
        int acc, d, mf;
        bit j;
        do_reset();
        send_req(1'b1, 1'b0, 16'h9423, acc);
        wait_pulse(1'b1, 30, d, mf, j);
        checks++; if (fee !== 8'd0) begin errors++; $display("[TB] FAIL sat_park_fee: got %0d want 0", fee); end
        repeat (300) @(posedge clock);
        #1;
        send_req(1'b0, 1'b1, 16'h9423, acc);
        wait_pulse(1'b1, 30, d, mf, j);
        checks++; if (fee !== 8'd255) begin errors++; $display("[TB] FAIL sat_fee: got %0d want 255", fee); end
        checks++; if (parked !== '0) begin errors++; $display("[TB] FAIL sat_clear: lot not empty after retrieve"); end
    endtask

    task automatic test_reset_mid();
        int acc, d, mf;
        bit j;
        do_reset();
        send_req(1'b1, 1'b0, 16'h8754, acc);
        wait_pulse(1'b1, 30, d, mf, j);
        leakage_mask = 7'b0000111;
        send_req(1'b1, 1'b0, 16'h1235, acc);
        repeat (2) begin @(posedge clock); #1; end
        checks++; if (current_floor !== 3'd1 || moving !== 16'h1235) begin errors++; $display("[TB] FAIL mid_before: floor %0d moving %h want 1/1235", current_floor, moving); end
        #2 reset = 1'b0;
        #1;
        checks++; if (current_floor !== 3'd0 || moving !== 16'h0) begin errors++; $display("[TB] FAIL mid_abort: floor %0d moving %h want 0/0", current_floor, moving); end
        checks++; if (parked !== '0 || req_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_state: ready %b, lot must be empty, want ready 1", req_ready); end
        #3 reset = 1'b1;
        leakage_mask = '0;
    endtask

    initial begin
        do_reset();
        test_reset();
        test_park_suv();
        test_fee();
        test_leakage();
        test_errors();
        test_full();
        test_saturate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/parking_lot_ctrl_param.md
# parking_lot_ctrl_param

Parametrised parking-lot controller: accepts park/retrieve requests at the ground floor, allocates slots across FLOORS floors, drives a single elevator one floor per cycle, stores plates and entry timestamps, and computes a saturating fee on exit. It sits under `parking_lot_top` as the next-generation core. Floor count, slots per floor, fee rate and widths are generic. It adds a valid/ready request handshake, per-floor leakage masking, duplicate/absent-plate rejection and time-based fees.

## Interface
- FLOORS, 7: parking floors 1..FLOORS; floor 0 is the entrance.
- SLOTS, 8: slots per floor; slots [0, SLOTS/2) are SUV, slots [SLOTS/2, SLOTS) are sedan.
- PLATE_W, 16: plate width, 4 BCD digits.
- FEE_W, 8: fee width.
- TIME_W, 16: timestamp counter width.
- RATE, 1: fee units per parked cycle.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- in_mode  in  1  park request.
- out_mode  in  1  retrieve request.
- license_plate  in  PLATE_W  plate for the request.
- leakage_mask  in  FLOORS  bit i-1 set means floor i is closed to new allocations.
- parked  out  FLOORS*SLOTS*PLATE_W  slot contents, floor-major; 0 means empty.
- current_floor  out  $clog2(FLOORS+1)  elevator position.
- moving  out  PLATE_W  plate in the elevator; 0 means empty.
- plate_type  out  1  1 = SUV (last digit odd) for the latched plate.
- fee  out  FEE_W  last exit fee, held.
- empty_suv, empty_sedan  out  $clog2(FLOORS*SLOTS/2+1)  free slots on unmasked floors.
- full_suv, full_sedan  out  1  the matching empty count is 0.
- done  out  1  one-cycle pulse when a request completes.
- err  out  1  one-cycle pulse when a request is rejected.

## Operation
- Reset values: all slots 0, all timestamps 0, current_floor 0, moving 0, fee 0, plate_type 0, done 0, err 0, state IDLE, cycle counter 0.
- The cycle counter increments every clock and wraps at 2^TIME_W.
- Handshake: a request is accepted on an edge where req_valid and req_ready are both high. The bench holds inputs stable until acceptance. The plate, mode and type are latched at acceptance.
- States: IDLE, SEARCH, UP, SERVICE, DOWN, RELEASE.
- IDLE → SEARCH on acceptance.
- SEARCH rejects the request when any of these hold:
  - in_mode equals out_mode;
  - the plate is 0;
  - on park, the plate is already parked;
  - on park, there is no free slot of the matching type on an unmasked floor;
  - on retrieve, the plate is not found.
- On rejection: err pulses and the FSM returns to IDLE.
- Park allocation picks the lowest unmasked floor, then the lowest free slot index of the matching type. moving is set to the plate.
- Retrieve targets the floor and slot holding the plate, regardless of leakage. The elevator travels up empty.
- The target floor and slot are latched in SEARCH. A later change to leakage_mask does not alter the operation in flight.
- UP: current_floor increments by 1 each edge. The FSM enters SERVICE on the edge where the floor reaches the target.
- SERVICE, park: write the plate into the slot, store the timestamp, clear moving.
- SERVICE, retrieve:
  - clear the slot;
  - set moving to the plate;
  - set fee = min((cnt − entry) mod 2^TIME_W × RATE, 2^FEE_W − 1).
- DOWN: current_floor decrements by 1 each edge; the FSM enters RELEASE on reaching 0.
- RELEASE: clear moving, pulse done, return to IDLE.
- Empty and full flags are combinational from slot occupancy and leakage_mask. A masked floor contributes 0 free slots.
- Reset asserted mid-operation aborts immediately to the reset values. The car in the elevator is lost.

## Timing
- Acceptance at edge T, target floor f:
  - SEARCH at T+1;
  - floor reaches f at T+1+f;
  - SERVICE edge at T+2+f;
  - floor reaches 0 at T+2+2f;
  - done high during the cycle after edge T+3+2f.
- Total latency is 2f+3 cycles.
- A rejected request has err high during the cycle after edge T+1. req_ready returns high on the same edge.
- current_floor never changes by more than 1 per cycle.
- fee updates only on a retrieve SERVICE edge.

## Test plan
- Park 9423 (SUV), empty lot, defaults → floor 1 slot 0 = 9423; floor path 0,1,0; done at accept+5; empty_suv 28→27.
- Park 8754 (sedan), then retrieve 8754 exactly 20 cycles after its SERVICE edge → slot 4 of floor 1 cleared; moving = 8754 during the descent; fee = 20.
- leakage_mask = 7'b0000001, then park 9423 → allocated to floor 2, latency 7 cycles; empty_suv reports 24 before the park.
- Fill all 28 SUV slots, then park 1111 → err pulse, no movement, full_suv = 1; a sedan park still succeeds.
- Error cases, each giving err with no state change:
  - retrieve an absent plate 5555;
  - park a duplicate 9423;
  - in_mode = out_mode = 1;
  - plate 0.
- Park so the fee exceeds 255 cycles (wait 300) → fee saturates at 255.
- Reset during UP → floor 0, moving 0, all slots 0, req_ready high.
